// File: rtl/program_run_sequencer_if.sv
// Launcher <-> core/host signal bundle for program_run_sequencer.
// slave  : sequencer side (takes requests and core status, drives core control and results)
// master : host/core side
// Optional RUN_CHECK_EN adds golden-value checking signals.
interface program_run_sequencer_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              start;
    logic [ADDR_W-1:0] start_pc_in;
    logic [ADDR_W-1:0] end_pc_in;
    logic [ADDR_W-1:0] currentpc;
    logic [DATA_W-1:0] m2r_in;
    logic              core_reset;
    logic [ADDR_W-1:0] core_startpc;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [DATA_W-1:0] result;
    logic [31:0]       cycle_count;
`ifdef RUN_CHECK_EN
    logic [DATA_W-1:0] expected_in;
    logic              pass;
    logic [7:0]        pass_count;

    modport slave (
        input  start, start_pc_in, end_pc_in, currentpc, m2r_in, expected_in,
        output core_reset, core_startpc, busy, done, timeout, result, cycle_count,
               pass, pass_count
    );
    modport master (
        output start, start_pc_in, end_pc_in, currentpc, m2r_in, expected_in,
        input  core_reset, core_startpc, busy, done, timeout, result, cycle_count,
               pass, pass_count
    );
`else
    modport slave (
        input  start, start_pc_in, end_pc_in, currentpc, m2r_in,
        output core_reset, core_startpc, busy, done, timeout, result, cycle_count
    );
    modport master (
        output start, start_pc_in, end_pc_in, currentpc, m2r_in,
        input  core_reset, core_startpc, busy, done, timeout, result, cycle_count
    );
`endif
endinterface

// File: rtl/program_run_sequencer.sv
// program_run_sequencer: launches a program on the singlecycle core, follows its PC
// up to an end address, captures the last MemtoRegOut inside the window and reports
// done / result / cycle count / watchdog timeout.
// Optional feature macro: RUN_CHECK_EN (golden-value compare, pass flag, pass counter).
//
// state    | meaning
// IDLE     | waiting for start; core_reset holds its last value
// CORE_RST | core_reset held high for RESET_CYCLES cycles
// SYNC     | waiting for the core PC to reach core_startpc
// RUN      | capturing m2r_in while currentpc < end
// DONE     | one-cycle done pulse, back to IDLE
module program_run_sequencer #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int RESET_CYCLES = 1,
    parameter int WDOG_W       = 16
) (
    input  logic                          CLK,
    input  logic                          reset,
    program_run_sequencer_if.slave        bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CORE_RST = 3'd1;
    localparam logic [2:0] SYNC     = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam int RC_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

    logic [2:0]        state;
    logic              core_reset_r;
    logic [ADDR_W-1:0] startpc_r;
    logic [ADDR_W-1:0] end_r;
    logic [DATA_W-1:0] result_r;
    logic [31:0]       count_r;
    logic              timeout_r;
    logic [WDOG_W-1:0] wdog;
    logic [RC_W-1:0]   rst_cnt;
    logic              run_phase;
    logic              wdog_hit;

    assign run_phase = (state == CORE_RST) || (state == SYNC) || (state == RUN);
    // Watchdog expiry overrides whatever the phase would otherwise do
    assign wdog_hit  = run_phase && (&wdog);

    // Main sequencer: launch, core reset pulse, PC sync, capture, watchdog
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            core_reset_r <= 1'b1;
            startpc_r    <= '0;
            end_r        <= '0;
            result_r     <= '0;
            count_r      <= '0;
            timeout_r    <= 1'b0;
            wdog         <= '0;
            rst_cnt      <= '0;
        end else if (wdog_hit) begin
            // Release the core so DONE always leaves it running, as on a normal exit
            timeout_r    <= 1'b1;
            core_reset_r <= 1'b0;
            state        <= DONE;
        end else begin
            if (run_phase) begin
                wdog <= wdog + WDOG_W'(1);
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        startpc_r <= bus.start_pc_in;
                        end_r     <= bus.end_pc_in;
                        result_r  <= '0;
                        count_r   <= '0;
                        timeout_r <= 1'b0;
                        wdog      <= '0;
                        rst_cnt   <= RC_W'(RESET_CYCLES);
                        state     <= CORE_RST;
                    end
                end
                CORE_RST: begin
                    // Count loaded on start: high for RESET_CYCLES, then release on the next edge
                    if (rst_cnt != '0) begin
                        core_reset_r <= 1'b1;
                        rst_cnt      <= rst_cnt - RC_W'(1);
                    end else begin
                        core_reset_r <= 1'b0;
                        state        <= SYNC;
                    end
                end
                SYNC: begin
                    if (bus.currentpc == startpc_r) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.currentpc < end_r) begin
                        result_r <= bus.m2r_in;
                        if (count_r != 32'hFFFF_FFFF) begin
                            count_r <= count_r + 32'd1;
                        end
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.core_reset   = core_reset_r;
    assign bus.core_startpc = startpc_r;
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.timeout      = timeout_r;
    assign bus.result       = result_r;
    assign bus.cycle_count  = count_r;

`ifdef RUN_CHECK_EN
    logic [DATA_W-1:0] expected_r;
    logic [7:0]        pass_count_r;
    logic              pass_w;

    assign pass_w = (state == DONE) && !timeout_r && (result_r == expected_r);

    // Golden value latched at launch; pass counter survives across runs until reset
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            expected_r   <= '0;
            pass_count_r <= '0;
        end else begin
            if ((state == IDLE) && bus.start) begin
                expected_r <= bus.expected_in;
            end
            if (pass_w) begin
                pass_count_r <= pass_count_r + 8'd1;
            end
        end
    end

    assign bus.pass       = pass_w;
    assign bus.pass_count = pass_count_r;
`endif

endmodule

// File: tb/tb_program_run_sequencer.sv
module tb_program_run_sequencer;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int RC = 1;
    localparam int WW = 10;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    program_run_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    program_run_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .RESET_CYCLES(RC), .WDOG_W(WW)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    // Stub core: reset registered once inside the core, so PC sits at startpc for the
    // cycle after core_reset falls, then advances by 4; m2r_in mirrors the PC.
    logic [AW-1:0] stub_pc;
    logic          stub_rst_q;
    logic          freeze = 1'b0;

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            stub_pc    <= '0;
            stub_rst_q <= 1'b1;
        end else begin
            stub_rst_q <= bus.core_reset;
            if (bus.core_reset || stub_rst_q) stub_pc <= bus.core_startpc;
            else                              stub_pc <= stub_pc + 64'd4;
        end
    end

    assign bus.currentpc = freeze ? 64'h10 : stub_pc;
    assign bus.m2r_in    = bus.currentpc;

    typedef struct {
        logic [DW-1:0] result;
        logic [31:0]   count;
        logic          timeout;
        logic          pass;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_passes = 0;

    task automatic launch(input logic [AW-1:0] spc, input logic [AW-1:0] epc,
                          input logic [DW-1:0] golden);
        @(negedge CLK);
        bus.start       = 1'b1;
        bus.start_pc_in = spc;
        bus.end_pc_in   = epc;
`ifdef RUN_CHECK_EN
        bus.expected_in = golden;
`else
        if (golden == '1) bus.start_pc_in = spc;
`endif
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(negedge CLK);
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++; if (bus.core_reset !== 1'b1) begin n_bad++; $display("FAIL reset.core_reset: got %b want 1", bus.core_reset); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin n_bad++; $display("FAIL reset.flags: got busy=%b done=%b timeout=%b want 0/0/0", bus.busy, bus.done, bus.timeout); end
        n_cmp++; if (bus.result !== '0 || bus.cycle_count !== 32'd0 || bus.core_startpc !== '0) begin n_bad++; $display("FAIL reset.data: got result=%h count=%0d startpc=%h want 0/0/0", bus.result, bus.cycle_count, bus.core_startpc); end
`ifdef RUN_CHECK_EN
        n_cmp++; if (bus.pass_count !== 8'd0 || bus.pass !== 1'b0) begin n_bad++; $display("FAIL reset.pass: got pass=%b count=%0d want 0/0", bus.pass, bus.pass_count); end
`endif
        reset = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        bit seen; int cyc; exp_t e;
        sb.push_back('{result: 64'h30, count: 32'd13, timeout: 1'b0, pass: 1'b1});
        exp_passes++;
        launch(64'h0, 64'h34, 64'h30);
        wait_done(2000, seen, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL basic.done: got no done within %0d cycles want done", cyc); end
        else begin
            if (cyc !== 17) begin n_bad++; $display("FAIL basic.latency: got done at %0d want 17", cyc); end
            n_cmp++; if (bus.result !== e.result) begin n_bad++; $display("FAIL basic.result: got %h want %h", bus.result, e.result); end
            n_cmp++; if (bus.cycle_count !== e.count) begin n_bad++; $display("FAIL basic.count: got %0d want %0d", bus.cycle_count, e.count); end
            n_cmp++; if (bus.timeout !== e.timeout) begin n_bad++; $display("FAIL basic.timeout: got %b want %b", bus.timeout, e.timeout); end
`ifdef RUN_CHECK_EN
            n_cmp++; if (bus.pass !== e.pass || bus.pass_count !== 8'(exp_passes)) begin n_bad++; $display("FAIL basic.pass: got %b/%0d want %b/%0d", bus.pass, bus.pass_count, e.pass, exp_passes); end
`endif
        end
        @(negedge CLK);
        n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.core_reset !== 1'b0) begin n_bad++; $display("FAIL basic.after: got done=%b busy=%b core_reset=%b want 0/0/0", bus.done, bus.busy, bus.core_reset); end
    endtask

    task automatic test_back_to_back();
        bit seen; int cyc; exp_t e;
        sb.push_back('{result: 64'h54, count: 32'd9, timeout: 1'b0, pass: 1'b1});
        exp_passes++;
        launch(64'h34, 64'h58, 64'h54);
        n_cmp++; if (bus.core_reset !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b.start_edge: got core_reset=%b busy=%b want 0/1", bus.core_reset, bus.busy); end
        @(negedge CLK);
        n_cmp++; if (bus.core_reset !== 1'b1) begin n_bad++; $display("FAIL b2b.core_reset_high: got %b want 1", bus.core_reset); end
        @(negedge CLK);
        n_cmp++; if (bus.core_reset !== 1'b0) begin n_bad++; $display("FAIL b2b.core_reset_release: got %b want 0", bus.core_reset); end
        wait_done(2000, seen, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL b2b.done: got no done within %0d cycles want done", cyc); end
        else begin
            n_cmp++; if (bus.result !== e.result) begin n_bad++; $display("FAIL b2b.result: got %h want %h", bus.result, e.result); end
            n_cmp++; if (bus.cycle_count !== e.count) begin n_bad++; $display("FAIL b2b.count: got %0d want %0d", bus.cycle_count, e.count); end
            n_cmp++; if (bus.core_startpc !== 64'h34) begin n_bad++; $display("FAIL b2b.startpc: got %h want 34", bus.core_startpc); end
`ifdef RUN_CHECK_EN
            n_cmp++; if (bus.pass !== e.pass || bus.pass_count !== 8'(exp_passes)) begin n_bad++; $display("FAIL b2b.pass: got %b/%0d want %b/%0d", bus.pass, bus.pass_count, e.pass, exp_passes); end
`endif
        end
    endtask

    task automatic test_timeout();
        bit seen; int cyc; exp_t e;
        freeze = 1'b1;
        sb.push_back('{result: 64'h0, count: 32'd0, timeout: 1'b1, pass: 1'b0});
        launch(64'h0, 64'h34, 64'h0);
        wait_done(3000, seen, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL wdog.done: got no done within %0d cycles want done", cyc); end
        else begin
            n_cmp++; if (cyc !== (1 << WW)) begin n_bad++; $display("FAIL wdog.latency: got done at %0d want %0d", cyc, (1 << WW)); end
            n_cmp++; if (bus.timeout !== e.timeout) begin n_bad++; $display("FAIL wdog.timeout: got %b want %b", bus.timeout, e.timeout); end
            n_cmp++; if (bus.result !== e.result || bus.cycle_count !== e.count) begin n_bad++; $display("FAIL wdog.data: got %h/%0d want %h/%0d", bus.result, bus.cycle_count, e.result, e.count); end
`ifdef RUN_CHECK_EN
            n_cmp++; if (bus.pass !== e.pass || bus.pass_count !== 8'(exp_passes)) begin n_bad++; $display("FAIL wdog.pass: got %b/%0d want %b/%0d", bus.pass, bus.pass_count, e.pass, exp_passes); end
`endif
        end
        @(negedge CLK);
        n_cmp++; if (bus.timeout !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL wdog.sticky: got timeout=%b busy=%b want 1/0", bus.timeout, bus.busy); end
        freeze = 1'b0;
    endtask

    task automatic test_empty_window();
        bit seen; int cyc; exp_t e;
        sb.push_back('{result: 64'h0, count: 32'd0, timeout: 1'b0, pass: 1'b1});
        exp_passes++;
        launch(64'h40, 64'h40, 64'h0);
        n_cmp++; if (bus.timeout !== 1'b0) begin n_bad++; $display("FAIL empty.timeout_cleared: got %b want 0", bus.timeout); end
        wait_done(2000, seen, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL empty.done: got no done within %0d cycles want done", cyc); end
        else begin
            n_cmp++; if (bus.result !== e.result || bus.cycle_count !== e.count || bus.timeout !== e.timeout) begin n_bad++; $display("FAIL empty.data: got %h/%0d/%b want %h/%0d/%b", bus.result, bus.cycle_count, bus.timeout, e.result, e.count, e.timeout); end
`ifdef RUN_CHECK_EN
            n_cmp++; if (bus.pass !== e.pass || bus.pass_count !== 8'(exp_passes)) begin n_bad++; $display("FAIL empty.pass: got %b/%0d want %b/%0d", bus.pass, bus.pass_count, e.pass, exp_passes); end
`endif
        end
    endtask

    task automatic test_start_ignored();
        bit seen; int cyc; exp_t e;
        sb.push_back('{result: 64'h30, count: 32'd13, timeout: 1'b0, pass: 1'b1});
        exp_passes++;
        launch(64'h0, 64'h34, 64'h30);
        repeat (8) @(negedge CLK);
        bus.start       = 1'b1;
        bus.start_pc_in = 64'h100;
        bus.end_pc_in   = 64'h200;
        @(negedge CLK);
        bus.start = 1'b0;
        n_cmp++; if (bus.core_startpc !== 64'h0 || bus.core_reset !== 1'b0) begin n_bad++; $display("FAIL ignore.relaunch: got startpc=%h core_reset=%b want 0/0", bus.core_startpc, bus.core_reset); end
        wait_done(2000, seen, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL ignore.done: got no done within %0d cycles want done", cyc); end
        else begin
            n_cmp++; if (bus.result !== e.result || bus.cycle_count !== e.count) begin n_bad++; $display("FAIL ignore.data: got %h/%0d want %h/%0d", bus.result, bus.cycle_count, e.result, e.count); end
        end
        @(negedge CLK);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ignore.queued: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_async_reset();
        bit seen; int cyc; exp_t e; int pulses;
        launch(64'h0, 64'h34, 64'h30);
        repeat (8) @(negedge CLK);
        reset = 1'b1;
        #1;
        exp_passes = 0;
        n_cmp++; if (bus.core_reset !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL areset.ctrl: got core_reset=%b busy=%b done=%b want 1/0/0", bus.core_reset, bus.busy, bus.done); end
        n_cmp++; if (bus.result !== '0 || bus.cycle_count !== 32'd0 || bus.timeout !== 1'b0) begin n_bad++; $display("FAIL areset.data: got %h/%0d/%b want 0/0/0", bus.result, bus.cycle_count, bus.timeout); end
`ifdef RUN_CHECK_EN
        n_cmp++; if (bus.pass_count !== 8'd0) begin n_bad++; $display("FAIL areset.pass_count: got %0d want 0", bus.pass_count); end
`endif
        pulses = 0;
        repeat (2) begin @(negedge CLK); if (bus.done === 1'b1) pulses++; end
        reset = 1'b0;
        repeat (20) begin @(negedge CLK); if (bus.done === 1'b1) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL areset.no_done: got %0d pulses want 0", pulses); end
        sb.push_back('{result: 64'h30, count: 32'd13, timeout: 1'b0, pass: 1'b1});
        exp_passes++;
        launch(64'h0, 64'h34, 64'h30);
        wait_done(2000, seen, cyc);
        e = sb.pop_front();
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL areset.rerun_done: got no done within %0d cycles want done", cyc); end
        else begin
            n_cmp++; if (bus.result !== e.result || bus.cycle_count !== e.count) begin n_bad++; $display("FAIL areset.rerun: got %h/%0d want %h/%0d", bus.result, bus.cycle_count, e.result, e.count); end
`ifdef RUN_CHECK_EN
            n_cmp++; if (bus.pass !== e.pass || bus.pass_count !== 8'(exp_passes)) begin n_bad++; $display("FAIL areset.pass: got %b/%0d want %b/%0d", bus.pass, bus.pass_count, e.pass, exp_passes); end
`endif
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.start_pc_in = '0;
        bus.end_pc_in   = '0;
`ifdef RUN_CHECK_EN
        bus.expected_in = '0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_empty_window();
        test_start_ignored();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running want finished");
        $fatal(1, "time limit");
    end
endmodule
